// File: rtl/cpu_pipe_pkg.sv
// ============================================================================
// cpu_pipe_pkg : shared types for the Decode->Execute pipeline register
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pipe_pkg;

  // Field order is fixed by the control unit; ld is the LSB.
  typedef struct packed {
    logic       wbs;
    logic       wme;
    logic       mm;
    logic [2:0] aluop;
    logic       wm;
    logic       am;
    logic       ni;
    logic       wre;
    logic       ld;
  } de_ctrl_t;

  localparam int CTRL_W = $bits(de_ctrl_t);

  typedef enum logic [0:0] {
    DE_RUN = 1'b0,
    DE_HAZ = 1'b1
  } de_state_t;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// load_use_detect : flags a Decode instruction that reads the register a load
//                   in Execute is about to write
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module load_use_detect #(
  parameter int REG_AW = 4
) (
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  input  logic              ex_valid_i,
  input  logic              ex_ld_i,
  input  logic              ex_wre_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              hz_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = use_rs1_i && (rs1_i == ex_rd_i);
  assign w_rs2_hit = use_rs2_i && (rs2_i == ex_rd_i);
  assign hz_o      = valid_i && ex_valid_i && ex_ld_i && ex_wre_i && (w_rs1_hit || w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/decode_execute_pipe.sv
// ============================================================================
// decode_execute_pipe : Decode->Execute register with valid/ready handshake,
//                       flush, load-use bubble insertion and stall counter
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module decode_execute_pipe
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [DATA_W-1:0] in_op_a,
  input  logic [DATA_W-1:0] in_op_b,
  input  logic [DATA_W-1:0] in_st_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [DATA_W-1:0] out_st_data,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  hazard_cnt
);

  localparam logic [2:0] c_stall_init = 3'(LOAD_STALL);

  de_state_t         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  de_ctrl_t          ctrl_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, st_q;
  logic [CNT_W-1:0]  hcnt_q;
  logic              w_hz;
  logic              w_load;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .valid_i    (in_valid),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .use_rs1_i  (in_use_rs1),
    .use_rs2_i  (in_use_rs2),
    .ex_valid_i (out_valid_q),
    .ex_ld_i    (ctrl_q.ld),
    .ex_wre_i   (ctrl_q.wre),
    .ex_rd_i    (rd_q),
    .hz_o       (w_hz)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    case (state_q)
      DE_RUN: begin
        in_ready = !flush && !w_hz && (!out_valid_q || out_ready);
        if (flush) begin
          out_valid_d = 1'b0;
          cnt_d       = 3'd0;
        end else if (w_hz) begin
          // A stalled load that cannot leave keeps both itself and Decode parked.
          if (out_ready) begin
            out_valid_d = 1'b0;
            cnt_d       = c_stall_init;
            state_d     = DE_HAZ;
          end
        end else if (in_valid && in_ready) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      DE_HAZ: begin
        in_ready    = (cnt_q == 3'd1) && !flush;
        out_valid_d = 1'b0;
        if (flush) begin
          state_d = DE_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          // The dependent instruction enters on the final bubble cycle.
          if (cnt_q <= 3'd1) begin
            state_d     = DE_RUN;
            out_valid_d = in_valid && in_ready;
          end
        end
      end
      default: begin
        state_d     = DE_RUN;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign w_load       = in_valid && in_ready;
  assign hazard_stall = in_valid && !in_ready && (w_hz || (state_q == DE_HAZ));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DE_RUN;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      st_q   <= '0;
    end else if (w_load) begin
      ctrl_q <= in_ctrl;
      rd_q   <= in_rd;
      op_a_q <= in_op_a;
      op_b_q <= in_op_b;
      st_q   <= in_st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
    end else if (hazard_stall && (hcnt_q != {CNT_W{1'b1}})) begin
      hcnt_q <= hcnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ctrl    = ctrl_q;
  assign out_rd      = rd_q;
  assign out_op_a    = op_a_q;
  assign out_op_b    = op_b_q;
  assign out_st_data = st_q;
  assign hazard_cnt  = hcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_execute_pipe.sv
// ============================================================================
// tb_decode_execute_pipe : directed tables, corner sequences and a randomized
//                          run against a bubble-count reference model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_decode_execute_pipe;

  localparam logic [10:0] MOV = 11'h042;
  localparam logic [10:0] LD  = 11'h103;
  localparam logic [10:0] SUB = 11'h022;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [10:0] in_ctrl;
  logic [3:0]  in_rd, in_rs1, in_rs2;
  logic        in_use_rs1, in_use_rs2;
  logic [15:0] in_op_a, in_op_b, in_st_data;

  logic        a_ir, a_ov, a_hs, b_ir, b_ov, b_hs;
  logic [10:0] a_ctrl, b_ctrl;
  logic [3:0]  a_rd, b_rd;
  logic [15:0] a_opa, a_opb, a_st, b_opa, b_opb, b_st;
  logic [15:0] a_hc;
  logic [3:0]  b_hc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_execute_pipe #(.DATA_W(16), .REG_AW(4), .LOAD_STALL(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_op_a(in_op_a),
    .in_op_b(in_op_b), .in_st_data(in_st_data), .out_valid(a_ov), .out_ready(out_ready),
    .out_ctrl(a_ctrl), .out_rd(a_rd), .out_op_a(a_opa), .out_op_b(a_opb),
    .out_st_data(a_st), .hazard_stall(a_hs), .hazard_cnt(a_hc)
  );

  decode_execute_pipe #(.DATA_W(16), .REG_AW(4), .LOAD_STALL(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_op_a(in_op_a),
    .in_op_b(in_op_b), .in_st_data(in_st_data), .out_valid(b_ov), .out_ready(out_ready),
    .out_ctrl(b_ctrl), .out_rd(b_rd), .out_op_a(b_opa), .out_op_b(b_opb),
    .out_st_data(b_st), .hazard_stall(b_hs), .hazard_cnt(b_hc)
  );

  // Per-instance views so the model loop can index both DUTs uniformly.
  logic        d_ir [2];
  logic        d_ov [2];
  logic        d_hs [2];
  logic [15:0] d_hc [2];
  logic [62:0] d_pay[2];
  assign d_ir[0] = a_ir;  assign d_ir[1] = b_ir;
  assign d_ov[0] = a_ov;  assign d_ov[1] = b_ov;
  assign d_hs[0] = a_hs;  assign d_hs[1] = b_hs;
  assign d_hc[0] = a_hc;  assign d_hc[1] = {12'd0, b_hc};
  assign d_pay[0] = {a_ctrl, a_rd, a_opa, a_opb, a_st};
  assign d_pay[1] = {b_ctrl, b_rd, b_opa, b_opb, b_st};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [10:0] c, input logic [3:0] rd,
                       input logic [3:0] r1, input logic [3:0] r2, input logic u1,
                       input logic u2, input logic [15:0] opb);
    in_valid   = iv;
    in_ctrl    = c;
    in_rd      = rd;
    in_rs1     = r1;
    in_rs2     = r2;
    in_use_rs1 = u1;
    in_use_rs2 = u2;
    in_op_a    = opb ^ 16'h5A5A;
    in_op_b    = opb;
    in_st_data = ~opb;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 11'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'd0);
    adv(); adv();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [10:0] c;
    logic [3:0]  rd, r1, r2;
    logic        u1, u2;
    logic [15:0] opb;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [15:0] e_opb;
    logic        e_hs;
    logic [15:0] e_hc;
  } vec_t;

  // Reference model: an entry slot, a count of remaining bubble cycles and a stall total.
  bit          m_valid[2];
  logic [62:0] m_pay  [2];
  int          m_bub  [2];
  int          m_cnt  [2];
  int          LS  [2] = '{1, 3};
  int          CMAX[2] = '{65535, 15};

  task automatic model_cycle();
    bit          hz, rdy, stl, nv;
    logic [62:0] inp, np;
    int          nb, nc;
    bit          cv[2];
    logic [62:0] cp[2];
    int          cb[2], cc[2];
    @(negedge clk);
    inp = {in_ctrl, in_rd, in_op_a, in_op_b, in_st_data};
    for (int i = 0; i < 2; i++) begin
      hz = in_valid && m_valid[i] && m_pay[i][52] && m_pay[i][53] &&
           ((in_use_rs1 && in_rs1 == m_pay[i][51:48]) || (in_use_rs2 && in_rs2 == m_pay[i][51:48]));
      if (m_bub[i] > 0) rdy = (m_bub[i] == 1) && !flush;
      else              rdy = !flush && !hz && (!m_valid[i] || out_ready);
      stl = in_valid && !rdy && (hz || m_bub[i] > 0);
      chk($sformatf("rnd%0d in_ready", i), {63'd0, d_ir[i]}, {63'd0, rdy});
      chk($sformatf("rnd%0d out_valid", i), {63'd0, d_ov[i]}, {63'd0, m_valid[i]});
      chk($sformatf("rnd%0d hazard_stall", i), {63'd0, d_hs[i]}, {63'd0, stl});
      chk($sformatf("rnd%0d hazard_cnt", i), {48'd0, d_hc[i]}, 64'(m_cnt[i]));
      if (m_valid[i]) chk($sformatf("rnd%0d payload", i), {1'b0, d_pay[i]}, {1'b0, m_pay[i]});
      nv = m_valid[i]; np = m_pay[i]; nb = m_bub[i];
      nc = (stl && m_cnt[i] < CMAX[i]) ? m_cnt[i] + 1 : m_cnt[i];
      if (in_valid && rdy) np = inp;
      if (rst) begin
        nv = 0; np = '0; nb = 0; nc = 0;
      end else if (flush) begin
        nv = 0; nb = 0;
      end else if (m_bub[i] > 0) begin
        nb = m_bub[i] - 1;
        nv = in_valid && rdy;
      end else if (hz) begin
        if (out_ready) begin nv = 0; nb = LS[i]; end
      end else if (in_valid && rdy) begin
        nv = 1;
      end else if (out_ready) begin
        nv = 0;
      end
      cv[i] = nv; cp[i] = np; cb[i] = nb; cc[i] = nc;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = cv[i]; m_pay[i] = cp[i]; m_bub[i] = cb[i]; m_cnt[i] = cc[i];
    end
    #1;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, MOV, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[1] = '{1'b1, MOV, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0007, 1'b0, 16'd0};
    tbl[2] = '{1'b1, LD,  4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 16'd0};
    tbl[3] = '{1'b1, SUB, 4'd2, 4'd8, 4'd1, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 16'd0};
    tbl[4] = '{1'b1, SUB, 4'd2, 4'd8, 4'd1, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd1};
    tbl[5] = '{1'b1, LD,  4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b1, 1'b1, 16'h0011, 1'b0, 16'd1};
    tbl[6] = '{1'b1, MOV, 4'd3, 4'd8, 4'd8, 1'b0, 1'b0, 16'h0033, 1'b1, 1'b1, 1'b1, 16'h0050, 1'b0, 16'd1};
    tbl[7] = '{1'b0, MOV, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0033, 1'b0, 16'd1};
    tbl[8] = '{1'b0, MOV, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd1};

    // Reset state of both instances.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset%0d out_valid", i), {63'd0, d_ov[i]}, 64'd0);
      chk($sformatf("reset%0d payload", i), {1'b0, d_pay[i]}, 64'd0);
      chk($sformatf("reset%0d hazard_cnt", i), {48'd0, d_hc[i]}, 64'd0);
      chk($sformatf("reset%0d in_ready", i), {63'd0, d_ir[i]}, 64'd1);
    end
    adv();

    // Streaming, single-bubble load-use and unused-source cases on the LOAD_STALL=1 instance.
    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].iv, tbl[k].c, tbl[k].rd, tbl[k].r1, tbl[k].r2, tbl[k].u1, tbl[k].u2, tbl[k].opb);
      out_ready = tbl[k].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d in_ready", k), {63'd0, a_ir}, {63'd0, tbl[k].e_ir});
      chk($sformatf("tbl%0d out_valid", k), {63'd0, a_ov}, {63'd0, tbl[k].e_ov});
      chk($sformatf("tbl%0d hazard_stall", k), {63'd0, a_hs}, {63'd0, tbl[k].e_hs});
      chk($sformatf("tbl%0d hazard_cnt", k), {48'd0, a_hc}, {48'd0, tbl[k].e_hc});
      if (tbl[k].e_ov) chk($sformatf("tbl%0d out_op_b", k), {48'd0, a_opb}, {48'd0, tbl[k].e_opb});
      adv();
    end

    // Three-bubble load-use with the load held in the stage for two cycles.
    do_reset();
    drive(1'b1, LD, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0040); adv();
    drive(1'b1, SUB, 4'd2, 4'd8, 4'd1, 1'b1, 1'b0, 16'h0011); out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold out_valid", {63'd0, b_ov}, 64'd1);
      chk("hold out_op_b", {48'd0, b_opb}, 64'h40);
      chk("hold in_ready", {63'd0, b_ir}, 64'd0);
      chk("hold hazard_stall", {63'd0, b_hs}, 64'd1);
      adv();
    end
    out_ready = 1'b1;
    @(negedge clk); chk("depart hazard_stall", {63'd0, b_hs}, 64'd1); adv();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bubble%0d out_valid", k), {63'd0, b_ov}, 64'd0);
      chk($sformatf("bubble%0d in_ready", k), {63'd0, b_ir}, (k == 2) ? 64'd1 : 64'd0);
      adv();
    end
    @(negedge clk);
    chk("dep out_valid", {63'd0, b_ov}, 64'd1);
    chk("dep out_op_b", {48'd0, b_opb}, 64'h11);
    chk("dep hazard_cnt", {60'd0, b_hc}, 64'd5);
    adv();

    // Flush in the second HAZ cycle aborts the stall.
    do_reset();
    drive(1'b1, LD, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0040); adv();
    drive(1'b1, SUB, 4'd2, 4'd8, 4'd1, 1'b1, 1'b0, 16'h0011); adv();
    @(negedge clk); chk("haz1 in_ready", {63'd0, b_ir}, 64'd0); adv();
    flush = 1'b1;
    @(negedge clk); chk("flush in_ready", {63'd0, b_ir}, 64'd0); adv();
    flush = 1'b0;
    @(negedge clk);
    chk("postflush out_valid", {63'd0, b_ov}, 64'd0);
    chk("postflush in_ready", {63'd0, b_ir}, 64'd1);
    adv();
    @(negedge clk); chk("postflush accept", {48'd0, b_opb}, 64'h11); adv();

    // Saturation of the 4-bit counter, then reset in the middle of a stall.
    do_reset();
    drive(1'b1, LD, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0040); adv();
    drive(1'b1, SUB, 4'd2, 4'd8, 4'd1, 1'b1, 1'b0, 16'h0011); out_ready = 1'b0;
    repeat (20) adv();
    @(negedge clk); chk("sat hazard_cnt", {60'd0, b_hc}, 64'd15);
    rst = 1'b1; adv(); rst = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", {63'd0, b_ov}, 64'd0);
    chk("midrst payload", {1'b0, d_pay[1]}, 64'd0);
    chk("midrst hazard_cnt", {60'd0, b_hc}, 64'd0);
    chk("midrst in_ready", {63'd0, b_ir}, 64'd1);
    adv();

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_pay[i] = '0; m_bub[i] = 0; m_cnt[i] = 0;
    end
    for (int n = 0; n < 600; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_ctrl    = 11'($urandom);
      in_ctrl[0] = ($urandom_range(0, 2) == 0);
      in_ctrl[1] = ($urandom_range(0, 3) != 0);
      in_rd      = 4'($urandom_range(0, 3));
      in_rs1     = 4'($urandom_range(0, 3));
      in_rs2     = 4'($urandom_range(0, 3));
      in_use_rs1 = 1'($urandom);
      in_use_rs2 = 1'($urandom);
      in_op_a    = 16'($urandom);
      in_op_b    = 16'($urandom);
      in_st_data = 16'($urandom);
      flush      = ($urandom_range(0, 19) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 149) == 0);
      model_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
